// File: rtl/cdr_ctrl_pkg.sv
// Shared types and defaults for the CDR acquisition/lock sequencer.
//   cdr_state_e : FSM state encoding, also exported on o_state
//   DEF_*       : default values for the sequencer parameters
//   cnt_w()     : counter width needed to hold values up to n
package cdr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_CDR = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } cdr_state_e;

  localparam int unsigned DEF_LOCK_EDGES  = 20;
  localparam int unsigned DEF_RST_CYCLES  = 8;
  localparam int unsigned DEF_ACQ_TIMEOUT = 1024;
  localparam int unsigned DEF_MAX_RUN     = 64;
  localparam int unsigned DEF_MAX_RETRY   = 3;

  // One spare bit above $clog2 so the terminal value always fits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cdr_run_timer.sv
// Edge-free run counter used for starvation detection.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : synchronous clear (wins over counting)
//   i_cnt_en     : count edge-free cycles while high
//   i_edge       : data transition pulse, restarts the run
//   o_starve_c   : combinational pulse on the MAX_RUN-th consecutive edge-free cycle
module cdr_run_timer
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RUN = DEF_MAX_RUN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  input  logic i_edge,
  output logic o_starve_c
);

  localparam int unsigned          RUN_W    = cnt_w(MAX_RUN);
  localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(MAX_RUN - 1);

  logic [RUN_W-1:0] r_run;
  logic             w_starve;

  // Starvation is flagged in the same cycle the FSM must act on it.
  assign w_starve   = i_cnt_en && !i_clr && !i_edge && (r_run == RUN_LAST);
  assign o_starve_c = w_starve;

  // Run length restarts on an edge and after each starvation event.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_run <= '0;
    end else if (i_cnt_en) begin
      if (i_edge || w_starve) begin
        r_run <= '0;
      end else if (r_run != '1) begin
        r_run <= r_run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR acquisition/lock sequencer: resets the CDR, requests training,
// counts transitions to declare lock, re-acquires on starvation and gives
// up after a bounded number of failed attempts.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_enable      : level, start/keep link acquisition
//   i_data_edge   : one-cycle pulse per detected data transition
//   o_cdr_rst     : holds CDR datapath in reset
//   o_train_req   : request training pattern from far end
//   o_lock        : CDR locked
//   o_lock_lost   : one-cycle pulse on loss of lock
//   o_fail        : sticky acquisition failure
//   o_state       : current FSM state encoding
module cdr_lock_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_EDGES  = DEF_LOCK_EDGES,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned ACQ_TIMEOUT = DEF_ACQ_TIMEOUT,
  parameter int unsigned MAX_RUN     = DEF_MAX_RUN,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_data_edge,
  output logic       o_cdr_rst,
  output logic       o_train_req,
  output logic       o_lock,
  output logic       o_lock_lost,
  output logic       o_fail,
  output logic [2:0] o_state
);

  // One timer serves both the reset hold and the acquisition budget.
  localparam int unsigned TMR_W = cnt_w((ACQ_TIMEOUT > RST_CYCLES) ? ACQ_TIMEOUT : RST_CYCLES);
  localparam int unsigned EDG_W = cnt_w(LOCK_EDGES);
  localparam int unsigned RTY_W = cnt_w(MAX_RETRY);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACQ_LAST = TMR_W'(ACQ_TIMEOUT - 1);
  localparam logic [EDG_W-1:0] EDG_LAST = EDG_W'(LOCK_EDGES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  cdr_state_e       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [EDG_W-1:0] r_edge_cnt;
  logic [RTY_W-1:0] r_retry_cnt;
  logic             r_cdr_rst;
  logic             r_train_req;
  logic             r_lock;
  logic             r_lock_lost;
  logic             r_fail;

  logic w_cnt_en;
  logic w_run_clr;
  logic w_starve;
  logic w_lock_hit;
  logic w_timeout;

  // Run counter only tracks edges while the CDR is out of reset.
  assign w_cnt_en  = (r_state == ST_ACQUIRE) || (r_state == ST_LOCKED);
  assign w_run_clr = !i_enable || !w_cnt_en;

  // The lock-completing edge takes precedence over a coincident timeout.
  assign w_lock_hit = (r_state == ST_ACQUIRE) && i_data_edge && (r_edge_cnt == EDG_LAST);
  assign w_timeout  = (r_state == ST_ACQUIRE) && (r_timer == ACQ_LAST);

  cdr_run_timer #(
    .MAX_RUN (MAX_RUN)
  ) u_run_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_run_clr),
    .i_cnt_en   (w_cnt_en),
    .i_edge     (i_data_edge),
    .o_starve_c (w_starve)
  );

  // Sequencer: state, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_edge_cnt  <= '0;
      r_retry_cnt <= '0;
      r_cdr_rst   <= 1'b1;
      r_train_req <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      if (!i_enable) begin
        // Disable is a quiet abort: no lock_lost pulse.
        r_state     <= ST_IDLE;
        r_timer     <= '0;
        r_edge_cnt  <= '0;
        r_retry_cnt <= '0;
        r_cdr_rst   <= 1'b1;
        r_train_req <= 1'b0;
        r_lock      <= 1'b0;
        r_fail      <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state     <= ST_RST_CDR;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_cdr_rst   <= 1'b1;
            r_train_req <= 1'b1;
          end

          ST_RST_CDR: begin
            if (r_timer == RST_LAST) begin
              r_state     <= ST_ACQUIRE;
              r_timer     <= '0;
              r_edge_cnt  <= '0;
              r_cdr_rst   <= 1'b0;
              r_train_req <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end

          ST_ACQUIRE: begin
            if (w_lock_hit) begin
              r_state     <= ST_LOCKED;
              r_timer     <= '0;
              r_edge_cnt  <= '0;
              r_retry_cnt <= '0;
              r_lock      <= 1'b1;
              r_train_req <= 1'b0;
              r_cdr_rst   <= 1'b0;
            end else if (w_timeout) begin
              r_timer    <= '0;
              r_edge_cnt <= '0;
              if (r_retry_cnt == RTY_LAST) begin
                r_state     <= ST_FAIL;
                r_fail      <= 1'b1;
                r_cdr_rst   <= 1'b1;
                r_train_req <= 1'b0;
              end else begin
                r_state     <= ST_RST_CDR;
                r_retry_cnt <= r_retry_cnt + 1'b1;
                r_cdr_rst   <= 1'b1;
                r_train_req <= 1'b1;
              end
            end else begin
              if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
              end
              // A starvation gap discards partial progress but not the attempt.
              if (i_data_edge) begin
                if (r_edge_cnt != '1) begin
                  r_edge_cnt <= r_edge_cnt + 1'b1;
                end
              end else if (w_starve) begin
                r_edge_cnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            if (w_starve) begin
              r_state     <= ST_RST_CDR;
              r_timer     <= '0;
              r_lock      <= 1'b0;
              r_lock_lost <= 1'b1;
              r_cdr_rst   <= 1'b1;
              r_train_req <= 1'b1;
            end
          end

          ST_FAIL: begin
          end

          default: begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_edge_cnt  <= '0;
            r_retry_cnt <= '0;
            r_cdr_rst   <= 1'b1;
            r_train_req <= 1'b0;
            r_lock      <= 1'b0;
            r_fail      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_cdr_rst   = r_cdr_rst;
  assign o_train_req = r_train_req;
  assign o_lock      = r_lock;
  assign o_lock_lost = r_lock_lost;
  assign o_fail      = r_fail;
  assign o_state     = r_state;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Scoreboard bench for cdr_lock_ctrl: a driver issues one input vector per
// cycle and queues the reference model's expected outputs; a monitor pops
// and compares after every clock edge.
module tb_cdr_lock_ctrl;

  localparam int LOCK_EDGES  = 20;
  localparam int RST_CYCLES  = 8;
  localparam int ACQ_TIMEOUT = 1024;
  localparam int MAX_RUN     = 64;
  localparam int MAX_RETRY   = 3;

  localparam int P_IDLE = 0;
  localparam int P_RST  = 1;
  localparam int P_ACQ  = 2;
  localparam int P_LOCK = 3;
  localparam int P_FAIL = 4;

  typedef struct packed {
    logic       cdr_rst;
    logic       train_req;
    logic       lock;
    logic       lock_lost;
    logic       fail;
    logic [2:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       data_edge = 1'b0;
  logic       cdr_rst, train_req, lock, lock_lost, fail;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  cdr_lock_ctrl #(
    .LOCK_EDGES  (LOCK_EDGES),
    .RST_CYCLES  (RST_CYCLES),
    .ACQ_TIMEOUT (ACQ_TIMEOUT),
    .MAX_RUN     (MAX_RUN),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_data_edge (data_edge),
    .o_cdr_rst   (cdr_rst),
    .o_train_req (train_req),
    .o_lock      (lock),
    .o_lock_lost (lock_lost),
    .o_fail      (fail),
    .o_state     (state_o)
  );

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   armed   = 1'b0;
  bit   done    = 1'b0;

  // Reference model: phase plus plain counts of what has happened in it.
  int m_phase   = P_IDLE;
  int m_cyc     = 0;  // cycles spent in the current phase
  int m_edges   = 0;  // edges counted toward lock in this window
  int m_quiet   = 0;  // consecutive edge-free cycles
  int m_attempt = 0;  // failed acquisitions since enable/lock

  task automatic enter(input int p);
    m_phase = p;
    m_cyc   = 0;
    m_edges = 0;
    m_quiet = 0;
  endtask

  function automatic obs_t outputs_of(input int p, input bit lost);
    obs_t o;
    o.cdr_rst   = (p == P_IDLE) || (p == P_RST) || (p == P_FAIL);
    o.train_req = (p == P_RST) || (p == P_ACQ);
    o.lock      = (p == P_LOCK);
    o.lock_lost = lost;
    o.fail      = (p == P_FAIL);
    o.state     = 3'(p);
    return o;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit edg, output obs_t e);
    bit lost;
    lost = 1'b0;
    if (r || !en) begin
      enter(P_IDLE);
      m_attempt = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          enter(P_RST);
          m_attempt = 0;
        end
        P_RST: begin
          if (m_cyc + 1 == RST_CYCLES) enter(P_ACQ);
          else m_cyc++;
        end
        P_ACQ: begin
          m_cyc++;
          if (edg) begin
            m_edges++;
            m_quiet = 0;
          end else begin
            m_quiet++;
            if (m_quiet == MAX_RUN) begin
              m_edges = 0;
              m_quiet = 0;
            end
          end
          if (m_edges == LOCK_EDGES) begin
            enter(P_LOCK);
            m_attempt = 0;
          end else if (m_cyc == ACQ_TIMEOUT) begin
            m_attempt++;
            if (m_attempt == MAX_RETRY) enter(P_FAIL);
            else enter(P_RST);
          end
        end
        P_LOCK: begin
          if (edg) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == MAX_RUN) begin
              lost = 1'b1;
              enter(P_RST);
            end
          end
        end
        default: ;
      endcase
    end
    e = outputs_of(m_phase, lost);
  endtask

  // Drive one cycle of inputs and queue the expected post-edge outputs.
  task automatic cycle(input bit r, input bit en, input bit edg);
    obs_t e;
    @(negedge clk);
    rst       = r;
    enable    = en;
    data_edge = edg;
    model_step(r, en, edg, e);
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic run_edges(input int n, input int period);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, (period != 0) && (i % period == period - 1));
  endtask

  task automatic wait_phase(input int p, input int bound);
    for (int i = 0; i < bound && m_phase != p; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic edges_until_lock(input int period, input int bound);
    for (int i = 0; i < bound && m_phase != P_LOCK; i++) cycle(1'b0, 1'b1, (i % period) == period - 1);
  endtask

  // Acquisition whose 20th edge lands `shift` cycles after the last timer value.
  task automatic collision_attempt(input int shift);
    int first;
    first = ACQ_TIMEOUT - 1 - (LOCK_EDGES - 1) * 50 + shift;
    for (int k = 0; k < ACQ_TIMEOUT + shift; k++)
      cycle(1'b0, 1'b1, (k >= first) && ((k - first) % 50 == 0));
  endtask

  // Monitor: one comparison per clock edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {cdr_rst, train_req, lock, lock_lost, fail, state_o};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got cdr_rst=%b train_req=%b lock=%b lock_lost=%b fail=%b state=%0d expected cdr_rst=%b train_req=%b lock=%b lock_lost=%b fail=%b state=%0d",
                   cyc, a.cdr_rst, a.train_req, a.lock, a.lock_lost, a.fail, a.state,
                   e.cdr_rst, e.train_req, e.lock, e.lock_lost, e.fail, e.state);
        end
      end else if (armed && !done) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow cyc=%0d got empty queue expected an entry", cyc);
      end
    end
  end

  // Driver: directed scenarios followed by a randomized soak.
  initial begin
    bit en_r, rst_r, edg_r;
    int den;

    // Reset and nominal lock
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    edges_until_lock(4, 300);
    run_edges(10, 4);

    // Starvation during acquire
    cycle(1'b0, 1'b0, 1'b0);
    wait_phase(P_ACQ, 20);
    run_edges(60, 4);
    run_edges(MAX_RUN, 0);
    edges_until_lock(4, 300);
    run_edges(5, 4);

    // Loss of lock and relock
    run_edges(MAX_RUN + 6, 0);
    edges_until_lock(4, 300);
    run_edges(5, 4);

    // Disable while locked
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Retry exhaustion, then release
    run_edges(MAX_RETRY * (RST_CYCLES + ACQ_TIMEOUT) + 10, 0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Lock edge coincides with timeout, then one cycle too late
    wait_phase(P_ACQ, 20);
    collision_attempt(0);
    run_edges(10, 4);
    cycle(1'b0, 1'b0, 1'b0);
    wait_phase(P_ACQ, 20);
    collision_attempt(1);
    run_edges(20, 0);

    // Synchronous reset mid-acquire while enabled
    cycle(1'b0, 1'b0, 1'b0);
    wait_phase(P_ACQ, 20);
    run_edges(20, 4);
    cycle(1'b1, 1'b1, 1'b1);
    run_edges(12, 4);

    // Randomized soak
    en_r = 1'b1;
    den  = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) den = $urandom_range(40, 1);
      if ($urandom_range(199, 0) == 0) en_r = !en_r;
      rst_r = ($urandom_range(999, 0) == 0);
      edg_r = ($urandom_range(den - 1, 0) == 0);
      cycle(rst_r, en_r, edg_r);
    end
    cycle(1'b0, 1'b0, 1'b0);

    done = 1'b1;
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
